// File: rtl/round_sched_pkg.sv
// Shared widths and saturation bounds for the shared rounding scheduler.
package round_sched_pkg;

  // Accumulator width: 4 guard bits plus integer and doubled fraction bits.
  function automatic int acc_w(input int il, input int fl);
    return 4 + 2 * (il + fl);
  endfunction

  // Rounded result width (signed Qil.fl).
  function automatic int out_w(input int il, input int fl);
    return il + fl;
  endfunction

  // Smallest accumulator value (2*fl fraction units) that clamps to the positive max.
  function automatic longint r_upper(input int il, input int fl);
    return ((longint'(1) << (il + fl - 1)) - 1) << fl;
  endfunction

  // Largest accumulator value that clamps to the negative min (-2^(il-1)).
  function automatic longint r_bottom(input int il, input int fl);
    return -(longint'(1) << (il - 1 + 2 * fl));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at/after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  logic                 found;
  logic [$clog2(N)-1:0] idx;

  // Scan from ptr upward and grant the first active request.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = $clog2(N)'((int'(ptr) + i) % N);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stochastic_rounding.sv
// Rounds a 2*FL-fraction accumulator to QIL.FL with LFSR dither and clamping.
module stochastic_rounding
  import round_sched_pkg::*;
#(
  parameter  int IL    = 4,
  parameter  int FL    = 16,
  localparam int ACC_W = acc_w(IL, FL),
  localparam int OUT_W = out_w(IL, FL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] acc_in,
  output logic [OUT_W-1:0] rnd_out
);

  localparam logic signed [ACC_W-1:0] R_UP  = ACC_W'(r_upper(IL, FL));
  localparam logic signed [ACC_W-1:0] R_BOT = ACC_W'(r_bottom(IL, FL));
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [31:0]   lfsr_q, lfsr_d;
  logic [FL-1:0] dither;
  logic          carry;

  // Galois LFSR step, polynomial x^32+x^22+x^2+x+1.
  always_comb lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);

  // Free-running dither source; never sits at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= 32'h1;
    else        lfsr_q <= lfsr_d;
  end

  // Round up exactly when dropped bits + dither carry out (frac > ~dither).
  always_comb begin
    dither = lfsr_q[FL-1:0];
    carry  = acc_in[FL-1:0] > ~dither;
    if ($signed(acc_in) >= R_UP)       rnd_out = OUT_MAX;
    else if ($signed(acc_in) <= R_BOT) rnd_out = OUT_MIN;
    else                               rnd_out = acc_in[FL +: OUT_W] + OUT_W'(carry);
  end

endmodule

// File: rtl/round_share_sched.sv
// Round-robin sharing of one stochastic rounder across N_REQ MAC lanes, 2-stage pipe.
module round_share_sched
  import round_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int IL    = 4,
  parameter  int FL    = 16,
  localparam int ACC_W = acc_w(IL, FL),
  localparam int OUT_W = out_w(IL, FL),
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*ACC_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic [ID_W-1:0]        out_id,
  input  logic                   out_ready,
  output logic [15:0]            sat_count,
  output logic                   busy
);

  typedef struct packed {
    logic [ACC_W-1:0] operand;
    logic [ID_W-1:0]  id;
    logic             sat;
  } s1_rec_t;

  localparam logic signed [ACC_W-1:0] R_UP  = ACC_W'(r_upper(IL, FL));
  localparam logic signed [ACC_W-1:0] R_BOT = ACC_W'(r_bottom(IL, FL));
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic             s1_valid_q, s1_valid_d;
  s1_rec_t          s1_q, s1_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]  out_id_q, out_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0]      sat_count_q, sat_count_d;

  logic             adv1, adv2, accept, in_sat;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic [ACC_W-1:0] in_op;
  logic [OUT_W-1:0] rnd;

  assign adv2 = !out_valid_q || out_ready;
  assign adv1 = !s1_valid_q || adv2;

  // Grants are masked while reset is held so nothing is accepted during reset.
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (adv1 && reset),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign accept    = |gnt;
  assign req_ready = gnt;
  assign in_op     = req_data[int'(gnt_idx)*ACC_W +: ACC_W];
  assign in_sat    = ($signed(in_op) >= R_UP) || ($signed(in_op) <= R_BOT);

  stochastic_rounding #(.IL(IL), .FL(FL)) u_rnd (
    .clk     (clk),
    .reset   (reset),
    .acc_in  (s1_q.operand),
    .rnd_out (rnd)
  );

  // Next state: S1 capture on adv1, S2 capture on adv2, pointer and counter on accept.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    sat_count_d = sat_count_q;
    if (adv1) begin
      s1_valid_d   = accept;
      s1_d.operand = in_op;
      s1_d.id      = gnt_idx;
      s1_d.sat     = in_sat;
    end
    if (accept) begin
      rr_ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
      if (in_sat && sat_count_q != 16'hFFFF) sat_count_d = sat_count_q + 16'd1;
    end
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_id_d   = s1_q.id;
        // Clamp from the flag counted at accept so data and count always agree.
        out_data_d = s1_q.sat ? (s1_q.operand[ACC_W-1] ? OUT_MIN : OUT_MAX) : rnd;
      end
    end
  end

  // Pipeline, pointer and counter registers; reset drops in-flight data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign sat_count = sat_count_q;
  assign busy      = s1_valid_q | out_valid_q;

endmodule
